// File: rtl/fft_pkg.sv
// fft_pkg: shared sample width, saturation, round-half-up halving and counter-width helpers for FFT stages
package fft_pkg;
  localparam int SAMPLE_W = 16;
  function automatic logic signed [63:0] sat(input logic signed [63:0] s, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
  function automatic logic signed [63:0] rhu(input logic signed [63:0] s);
    return (s + 64'sd1) >>> 1;
  endfunction
  function automatic int cnt_w(input int depth);
    return $clog2(2 * depth);
  endfunction
endpackage

// File: rtl/delay_en.sv
// delay_en: DEPTH-deep complex shift register with shift enable and sync clear; q is the oldest entry
module delay_en #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] d_r,
  input  logic signed [WIDTH-1:0] d_i,
  output logic signed [WIDTH-1:0] q_r,
  output logic signed [WIDTH-1:0] q_i
);
  logic signed [WIDTH-1:0] mem_r [DEPTH];
  logic signed [WIDTH-1:0] mem_i [DEPTH];
  always_ff @(posedge clk)
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_r[k] <= '0;
        mem_i[k] <= '0;
      end
    end else if (en) begin
      mem_r[0] <= d_r;
      mem_i[0] <= d_i;
      for (int k = 1; k < DEPTH; k++) begin
        mem_r[k] <= mem_r[k-1];
        mem_i[k] <= mem_i[k-1];
      end
    end
  assign q_r = mem_r[DEPTH-1];
  assign q_i = mem_i[DEPTH-1];
endmodule

// File: rtl/bf2i_stage.sv
// bf2i_stage: radix-2^2 SDF BF2I butterfly (clk, sync rst, i_valid/i_rZ/i_iZ in, o_valid/o_sof/o_rZ/o_iZ out); BF2_SCALE_EN halves with round-half-up instead of saturating
module bf2i_stage
  import fft_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic signed [WIDTH-1:0] i_rZ,
  input  logic signed [WIDTH-1:0] i_iZ,
  output logic                    o_valid,
  output logic                    o_sof,
  output logic signed [WIDTH-1:0] o_rZ,
  output logic signed [WIDTH-1:0] o_iZ
);
  localparam int CW = cnt_w(DEPTH);
  logic [CW-1:0] cnt;
  logic primed, phase_b;
  logic signed [WIDTH-1:0] d_r, d_i, w_r, w_i, c_r, c_i;
  function automatic logic signed [WIDTH-1:0] red(input logic signed [WIDTH:0] s);
    logic signed [63:0] t;
`ifdef BF2_SCALE_EN
    t = rhu(64'(s));
`else
    t = sat(64'(s), WIDTH);
`endif
    return t[WIDTH-1:0];
  endfunction
  always_comb begin
    phase_b = cnt >= CW'(DEPTH);
    c_r = phase_b ? red((WIDTH+1)'(d_r) + (WIDTH+1)'(i_rZ)) : d_r;
    c_i = phase_b ? red((WIDTH+1)'(d_i) + (WIDTH+1)'(i_iZ)) : d_i;
    w_r = phase_b ? red((WIDTH+1)'(d_r) - (WIDTH+1)'(i_rZ)) : i_rZ;
    w_i = phase_b ? red((WIDTH+1)'(d_i) - (WIDTH+1)'(i_iZ)) : i_iZ;
  end
  delay_en #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_delay (
    .clk (clk),
    .rst (rst),
    .en  (i_valid),
    .d_r (w_r),
    .d_i (w_i),
    .q_r (d_r),
    .q_i (d_i)
  );
  always_ff @(posedge clk)
    if (rst) begin
      cnt     <= '0;
      primed  <= 1'b0;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_rZ    <= '0;
      o_iZ    <= '0;
    end else begin
      o_valid <= i_valid && primed;
      o_sof   <= i_valid && cnt == CW'(DEPTH);
      if (i_valid) begin
        o_rZ <= c_r;
        o_iZ <= c_i;
        cnt  <= cnt + 1'b1;
        if (cnt == CW'(DEPTH - 1)) primed <= 1'b1;
      end
    end
endmodule

// File: tb/tb_bf2i_stage.sv
// tb_bf2i_stage: directed scoreboard bench for bf2i_stage with a reference model of the butterfly
module tb_bf2i_stage;
  localparam int D = 8;
  localparam int W = 16;
  typedef struct {
    logic v;
    logic s;
    logic signed [W-1:0] r;
    logic signed [W-1:0] i;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic signed [W-1:0] i_rZ = '0;
  logic signed [W-1:0] i_iZ = '0;
  logic o_valid, o_sof;
  logic signed [W-1:0] o_rZ, o_iZ;
  int checks = 0;
  int errors = 0;
  string tag = "reset";
  exp_t sb[$];
  int got[$];
  bit record = 1'b0;
  int m_cnt = 0;
  bit m_primed = 1'b0;
  int m_dr[$];
  int m_di[$];
  exp_t m_out = '{1'b0, 1'b0, '0, '0};
  bf2i_stage #(.DEPTH(D), .WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_rZ    (i_rZ),
    .i_iZ    (i_iZ),
    .o_valid (o_valid),
    .o_sof   (o_sof),
    .o_rZ    (o_rZ),
    .o_iZ    (o_iZ)
  );
  always #5 clk = ~clk;
  function automatic int red(input int s);
`ifdef BF2_SCALE_EN
    return (s + 1) >>> 1;
`else
    return s > 32767 ? 32767 : s < -32768 ? -32768 : s;
`endif
  endfunction
  task automatic model_reset();
    m_cnt = 0;
    m_primed = 1'b0;
    m_dr.delete();
    m_di.delete();
    for (int k = 0; k < D; k++) begin
      m_dr.push_back(0);
      m_di.push_back(0);
    end
    m_out = '{1'b0, 1'b0, '0, '0};
  endtask
  task automatic step(input bit r, input bit v, input int re, input int im);
    int hr, hi, cr, ci, wr, wi;
    exp_t e;
    @(negedge clk);
    rst = r;
    i_valid = v;
    i_rZ = W'(re);
    i_iZ = W'(im);
    if (r) model_reset();
    else if (v) begin
      hr = m_dr.pop_front();
      hi = m_di.pop_front();
      if (m_cnt >= D) begin
        cr = red(hr + re);
        ci = red(hi + im);
        wr = red(hr - re);
        wi = red(hi - im);
      end else begin
        cr = hr;
        ci = hi;
        wr = re;
        wi = im;
      end
      m_dr.push_back(wr);
      m_di.push_back(wi);
      m_out = '{m_primed, m_cnt == D, W'(cr), W'(ci)};
      if (m_cnt == D - 1) m_primed = 1'b1;
      m_cnt = (m_cnt + 1) % (2 * D);
    end else begin
      m_out.v = 1'b0;
      m_out.s = 1'b0;
    end
    sb.push_back(m_out);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    assert (o_valid === e.v && o_sof === e.s && o_rZ === e.r && o_iZ === e.i)
    else begin
      errors++;
      $error("FAIL %s: got v=%0b sof=%0b re=%0d im=%0d, expected v=%0b sof=%0b re=%0d im=%0d",
             tag, o_valid, o_sof, o_rZ, o_iZ, e.v, e.s, e.r, e.i);
    end
    if (record && o_valid === 1'b1) got.push_back(int'(o_rZ));
  endtask
  task automatic ramp_frames(input bit gaps);
    for (int n = 0; n < 2 * D; n++) begin
      step(1'b0, 1'b1, n, 0);
      if (gaps) step(1'b0, 1'b0, 0, 0);
    end
    for (int n = 0; n < 2 * D; n++) begin
      step(1'b0, 1'b1, 0, 0);
      if (gaps) step(1'b0, 1'b0, 0, 0);
    end
  endtask
  initial begin
    int ev;
    model_reset();
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 5, 5);
    tag = "ramp";
    record = 1'b1;
    ramp_frames(1'b0);
    record = 1'b0;
    checks++;
    assert (got.size() >= 2 * D)
    else begin
      errors++;
      $error("FAIL ramp_count: got %0d outputs, expected at least %0d", got.size(), 2 * D);
    end
    for (int k = 0; k < 2 * D && k < got.size(); k++) begin
`ifdef BF2_SCALE_EN
      ev = k < D ? 4 + k : -4;
`else
      ev = k < D ? 8 + 2 * k : -8;
`endif
      checks++;
      assert (got[k] === ev)
      else begin
        errors++;
        $error("FAIL ramp_value[%0d]: got %0d, expected %0d", k, got[k], ev);
      end
    end
    tag = "gaps";
    step(1'b1, 1'b0, 0, 0);
    ramp_frames(1'b1);
    tag = "saturate";
    step(1'b1, 1'b0, 0, 0);
    for (int n = 0; n < 2 * D; n++) step(1'b0, 1'b1, 32767, -32768);
    for (int n = 0; n < 2 * D; n++) step(1'b0, 1'b1, n < D ? -32768 : 32767, n < D ? 32767 : -32768);
    for (int n = 0; n < D; n++) step(1'b0, 1'b1, 0, 0);
    tag = "mid_reset";
    step(1'b1, 1'b0, 0, 0);
    for (int n = 0; n < 6; n++) step(1'b0, 1'b1, 100 + n, -n);
    step(1'b1, 1'b0, 0, 0);
    ramp_frames(1'b0);
    tag = "reset_with_valid";
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 777, -777);
    for (int n = 0; n < 2 * D; n++) step(1'b0, 1'b1, 3 * n - 20, 1000 - 50 * n);
    for (int n = 0; n < D; n++) step(1'b0, 1'b1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
